// File: rtl/spi_sram_model.sv
// spi_sram_model: behavioural model of a 23LCxxxx-style serial SPI SRAM.
//
// Commands: 03 READ, 0B FAST READ (DUMMY_CYCLES dummy clocks), 02 WRITE,
// 05 RDMR (read mode register), 01 WRMR (write mode register).
// Addressing follows mode[7:6]: 00 byte, 10 page, 01/11 sequential.
//
// Ports:
//   sclk    in   SPI clock, the only clock; si is sampled on rising edges,
//                so/so_oe are updated on falling edges
//   reset_n in   asynchronous active-low reset (memory contents are kept)
//   ce      in   chip enable, active high
//   si      in   serial data in, MSB first
//   so      out  serial data out
//   so_oe   out  high while so carries read data
//   err     out  sticky protocol-error flag
//
// Optional feature: define SPI_SRAM_MODEL_STRICT_EN to enable err and the
// protocol-error messages; otherwise err is tied low.
module spi_sram_model #(
  parameter string       INIT_FILE    = "",
  parameter int unsigned ADDR_BITS    = 24,
  parameter int unsigned MEM_BYTES    = 2**23,
  parameter int unsigned PAGE_BYTES   = 32,
  parameter int unsigned DUMMY_CYCLES = 8,
  parameter logic [7:0]  MODE_RESET   = 8'h40
) (
  input  logic sclk,
  input  logic reset_n,
  input  logic ce,
  input  logic si,
  output logic so,
  output logic so_oe,
  output logic err
);

  localparam int unsigned MEM_AW = $clog2(MEM_BYTES);
  localparam logic [ADDR_BITS-1:0] PAGE_MASK = ADDR_BITS'(PAGE_BYTES - 1);
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  typedef enum logic [2:0] {
    ST_CMD, ST_ADDR, ST_DUMMY, ST_SEND, ST_RECV, ST_WMODE, ST_HALT
  } state_e;

  logic [7:0] mem [MEM_BYTES];

  state_e                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [6:0]            shreg_q, shreg_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [15:0]           dcnt_q, dcnt_d;
  logic [7:0]            mode_q, mode_d;
  logic                  so_q, so_oe_q;

  logic [7:0] rx_byte_s;
  logic [7:0] send_byte_s;
  logic       we_s;
  logic       err_set_s;
  logic [1:0] cause_s;

  // Advance an address according to the addressing mode; sequential wrap
  // at MEM_BYTES falls out of the modulo indexing.
  function automatic logic [ADDR_BITS-1:0] next_addr(input logic [ADDR_BITS-1:0] a,
                                                     input logic [1:0] m);
    logic [ADDR_BITS-1:0] inc;
    inc = a + {{(ADDR_BITS-1){1'b0}}, 1'b1};
    if (m == 2'b10) begin
      next_addr = (a & ~PAGE_MASK) | (inc & PAGE_MASK);
    end else begin
      next_addr = inc;
    end
  endfunction

  assign rx_byte_s   = {shreg_q, si};
  assign send_byte_s = (cmd_q == 8'h05) ? mode_q : mem[addr_q[MEM_AW-1:0]];

  // Next-state logic of the protocol FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    dcnt_d    = dcnt_q;
    mode_d    = mode_q;
    we_s      = 1'b0;
    err_set_s = 1'b0;
    cause_s   = 2'd0;
    if (!ce) begin
      state_d = ST_CMD;
      cnt_d   = 6'd7;
      // A bit counter off a byte boundary means a byte was cut short.
      if ((state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_WMODE ||
           state_q == ST_RECV) && (cnt_q[2:0] != 3'd7)) begin
        err_set_s = 1'b1;
        cause_s   = 2'd1;
      end else begin
        err_set_s = 1'b0;
      end
    end else begin
      case (state_q)
        ST_CMD: begin
          shreg_d = rx_byte_s[6:0];
          if (cnt_q == 6'd0) begin
            cmd_d = rx_byte_s;
            cnt_d = 6'd7;
            case (rx_byte_s)
              8'h03, 8'h0B, 8'h02: begin
                state_d = ST_ADDR;
                cnt_d   = 6'(ADDR_BITS - 1);
              end
              8'h05:   state_d = ST_SEND;
              8'h01:   state_d = ST_WMODE;
              default: begin
                state_d   = ST_HALT;
                err_set_s = 1'b1;
                cause_s   = 2'd0;
              end
            endcase
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        ST_ADDR: begin
          addr_d = {addr_q[ADDR_BITS-2:0], si};
          if (cnt_q == 6'd0) begin
            cnt_d = 6'd7;
            if (33'(addr_d) >= MEM_LIMIT) begin
              err_set_s = 1'b1;
              cause_s   = 2'd2;
            end else begin
              err_set_s = 1'b0;
            end
            case (cmd_q)
              8'h0B: begin
                if (DUMMY_CYCLES == 0) begin
                  state_d = ST_SEND;
                end else begin
                  state_d = ST_DUMMY;
                  dcnt_d  = 16'(DUMMY_CYCLES) - 16'd1;
                end
              end
              8'h02:   state_d = ST_RECV;
              default: state_d = ST_SEND;
            endcase
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        ST_DUMMY: begin
          if (dcnt_q == 16'd0) begin
            state_d = ST_SEND;
            cnt_d   = 6'd7;
          end else begin
            dcnt_d = dcnt_q - 16'd1;
          end
        end
        ST_SEND: begin
          if (cnt_q == 6'd0) begin
            cnt_d = 6'd7;
            // RDMR keeps repeating the mode byte; memory reads advance.
            if (cmd_q != 8'h05) begin
              addr_d = next_addr(addr_q, mode_q[7:6]);
              if (mode_q[7:6] == 2'b00) state_d = ST_HALT;
              else                      state_d = ST_SEND;
            end else begin
              state_d = ST_SEND;
            end
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        ST_RECV: begin
          shreg_d = rx_byte_s[6:0];
          if (cnt_q == 6'd0) begin
            we_s   = 1'b1;
            cnt_d  = 6'd7;
            addr_d = next_addr(addr_q, mode_q[7:6]);
            if (mode_q[7:6] == 2'b00) state_d = ST_HALT;
            else                      state_d = ST_RECV;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        ST_WMODE: begin
          shreg_d = rx_byte_s[6:0];
          if (cnt_q == 6'd0) begin
            mode_d  = rx_byte_s;
            state_d = ST_HALT;
            if (rx_byte_s[5:0] != 6'd0) begin
              err_set_s = 1'b1;
              cause_s   = 2'd3;
            end else begin
              err_set_s = 1'b0;
            end
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        ST_HALT: state_d = ST_HALT;
        default: begin
          state_d = ST_CMD;
          cnt_d   = 6'd7;
        end
      endcase
    end
  end

  // Protocol state registers, advanced on rising sclk.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_CMD;
      cnt_q   <= 6'd7;
      shreg_q <= 7'd0;
      cmd_q   <= 8'h00;
      addr_q  <= '0;
      dcnt_q  <= 16'd0;
      mode_q  <= MODE_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      dcnt_q  <= dcnt_d;
      mode_q  <= mode_d;
    end
  end

  // Memory write port; no reset so contents survive reset_n.
  always_ff @(posedge sclk) begin
    if (we_s) mem[addr_q[MEM_AW-1:0]] <= rx_byte_s;
  end

  // Serial output, launched on falling sclk so the master samples it on the
  // following rising edge.
  always_ff @(negedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      so_q    <= 1'b0;
      so_oe_q <= 1'b0;
    end else if (state_q == ST_SEND) begin
      so_q    <= send_byte_s[cnt_q[2:0]];
      so_oe_q <= 1'b1;
    end else begin
      so_q    <= 1'b0;
      so_oe_q <= 1'b0;
    end
  end

  assign so    = so_q;
  assign so_oe = so_oe_q;

`ifdef SPI_SRAM_MODEL_STRICT_EN
  logic err_q;

  // Sticky error flag, cleared only by reset_n.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n)       err_q <= 1'b0;
    else if (err_set_s) err_q <= 1'b1;
    else                err_q <= err_q;
  end

  // One message per detected protocol error.
  always_ff @(posedge sclk) begin
    if (reset_n && err_set_s) begin
      case (cause_s)
        2'd0:    $error("%0t spi_sram_model: unknown command %h", $time, rx_byte_s);
        2'd1:    $error("%0t spi_sram_model: ce dropped mid-byte", $time);
        2'd2:    $error("%0t spi_sram_model: address %h beyond memory", $time, addr_d);
        default: $error("%0t spi_sram_model: bad mode value %h", $time, rx_byte_s);
      endcase
    end
  end

  assign err = err_q;
`else
  logic unused_err_s;
  assign unused_err_s = ^{err_set_s, cause_s};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_sram_model.sv
module tb_spi_sram_model;

  logic sclk = 1'b0;
  logic reset_n;
  logic ce;
  logic si;
  logic so;
  logic so_oe;
  logic err;

  int n_total = 0;
  int n_bad   = 0;

  spi_sram_model #(
    .INIT_FILE   (""),
    .ADDR_BITS   (24),
    .MEM_BYTES   (1024),
    .PAGE_BYTES  (32),
    .DUMMY_CYCLES(8),
    .MODE_RESET  (8'h40)
  ) dut (
    .sclk   (sclk),
    .reset_n(reset_n),
    .ce     (ce),
    .si     (si),
    .so     (so),
    .so_oe  (so_oe),
    .err    (err)
  );

  always #10 sclk = ~sclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bit: so/so_oe are sampled 2 ns after the falling edge (the bit the
  // master would capture on the coming rising edge), then si is driven.
  task automatic spi_bit(input logic b, output logic r, output logic oe);
    @(negedge sclk);
    #2;
    r  = so;
    oe = so_oe;
    ce = 1'b1;
    si = b;
    @(posedge sclk);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx,
                          output logic oe_any, output logic oe_all);
    logic r, oe;
    oe_any = 1'b0;
    oe_all = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r, oe);
      rx[i]  = r;
      oe_any = oe_any | oe;
      oe_all = oe_all & oe;
    end
  endtask

  task automatic spi_end;
    @(negedge sclk);
    #2;
    ce = 1'b0;
    si = 1'b0;
    @(posedge sclk);
    @(negedge sclk);
    #2;
  endtask

  // Command plus 24-bit address; reports whether so_oe was ever high.
  task automatic cmd_addr(input logic [7:0] cmd, input logic [23:0] a, output logic oe_seen);
    logic [7:0] rx;
    logic oa, ol;
    oe_seen = 1'b0;
    spi_byte(cmd, rx, oa, ol);     oe_seen = oe_seen | oa;
    spi_byte(a[23:16], rx, oa, ol); oe_seen = oe_seen | oa;
    spi_byte(a[15:8], rx, oa, ol);  oe_seen = oe_seen | oa;
    spi_byte(a[7:0], rx, oa, ol);   oe_seen = oe_seen | oa;
  endtask

  task automatic write_byte(input logic [23:0] a, input logic [7:0] d);
    logic [7:0] rx;
    logic oa, ol, oe_seen;
    cmd_addr(8'h02, a, oe_seen);
    spi_byte(d, rx, oa, ol);
    spi_end();
  endtask

  task automatic write_mode(input logic [7:0] m);
    logic [7:0] rx;
    logic oa, ol;
    spi_byte(8'h01, rx, oa, ol);
    spi_byte(m, rx, oa, ol);
    spi_end();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    logic oa, ol, oe_seen, r, oe;

    reset_n = 1'b0;
    ce      = 1'b0;
    si      = 1'b0;
    #35;
    check_val("reset_so", 32'(so), 32'd0);
    check_val("reset_so_oe", 32'(so_oe), 32'd0);
    check_val("reset_err", 32'(err), 32'd0);
    #10;
    reset_n = 1'b1;

    // RDMR repeats the reset mode byte
    spi_byte(8'h05, rx, oa, ol);
    check_val("rdmr_cmd_oe", 32'(oa), 32'd0);
    spi_byte(8'h00, rx, oa, ol);
    check_val("rdmr_b0", 32'(rx), 32'h40);
    check_val("rdmr_b0_oe", 32'(ol), 32'd1);
    spi_byte(8'h00, rx, oa, ol);
    check_val("rdmr_b1", 32'(rx), 32'h40);
    spi_end();
    check_val("rdmr_end_oe", 32'(so_oe), 32'd0);

    // sequential write of three bytes, then read back
    cmd_addr(8'h02, 24'h000010, oe_seen);
    spi_byte(8'hA5, rx, oa, ol);
    spi_byte(8'h5A, rx, oa, ol);
    spi_byte(8'hC3, rx, oa, ol);
    spi_end();
    cmd_addr(8'h03, 24'h000010, oe_seen);
    check_val("read_hdr_oe", 32'(oe_seen), 32'd0);
    spi_byte(8'h00, rx, oa, ol);
    check_val("read_b0", 32'(rx), 32'hA5);
    check_val("read_b0_oe", 32'(ol), 32'd1);
    spi_byte(8'h00, rx, oa, ol);
    check_val("read_b1", 32'(rx), 32'h5A);
    spi_byte(8'h00, rx, oa, ol);
    check_val("read_b2", 32'(rx), 32'hC3);
    spi_end();

    // page mode wrap from 0x1F to 0x00; 0x20 must stay untouched
    write_byte(24'h000020, 8'h77);
    write_mode(8'h80);
    spi_byte(8'h05, rx, oa, ol);
    spi_byte(8'h00, rx, oa, ol);
    check_val("rdmr_page", 32'(rx), 32'h80);
    spi_end();
    cmd_addr(8'h02, 24'h00001F, oe_seen);
    spi_byte(8'h11, rx, oa, ol);
    spi_byte(8'h22, rx, oa, ol);
    spi_end();
    cmd_addr(8'h03, 24'h00001F, oe_seen);
    spi_byte(8'h00, rx, oa, ol);
    check_val("page_rd_b0", 32'(rx), 32'h11);
    spi_byte(8'h00, rx, oa, ol);
    check_val("page_rd_b1", 32'(rx), 32'h22);
    spi_end();
    write_mode(8'h40);
    cmd_addr(8'h03, 24'h00001F, oe_seen);
    spi_byte(8'h00, rx, oa, ol);
    check_val("seq_rd_1f", 32'(rx), 32'h11);
    spi_byte(8'h00, rx, oa, ol);
    check_val("seq_rd_20", 32'(rx), 32'h77);
    spi_end();
    cmd_addr(8'h03, 24'h000000, oe_seen);
    spi_byte(8'h00, rx, oa, ol);
    check_val("page_wrap_mem0", 32'(rx), 32'h22);
    spi_end();

    // sequential wrap from MEM_BYTES-1 to 0, and upper address bits dropped
    write_byte(24'h0003FF, 8'h9C);
    cmd_addr(8'h03, 24'h0003FF, oe_seen);
    spi_byte(8'h00, rx, oa, ol);
    check_val("seq_top", 32'(rx), 32'h9C);
    spi_byte(8'h00, rx, oa, ol);
    check_val("seq_wrap0", 32'(rx), 32'h22);
    spi_end();
    cmd_addr(8'h03, 24'h000410, oe_seen);
    spi_byte(8'h00, rx, oa, ol);
    check_val("addr_mod", 32'(rx), 32'hA5);
    spi_end();

    // FAST READ: 8 dummy clocks with si ignored, then data
    cmd_addr(8'h0B, 24'h000010, oe_seen);
    spi_byte(8'hFF, rx, oa, ol);
    check_val("fast_dummy_oe", 32'(oa), 32'd0);
    spi_byte(8'h00, rx, oa, ol);
    check_val("fast_b0", 32'(rx), 32'hA5);
    spi_byte(8'h00, rx, oa, ol);
    check_val("fast_b1", 32'(rx), 32'h5A);
    spi_end();

    // partial WRITE byte is discarded
    cmd_addr(8'h02, 24'h000011, oe_seen);
    spi_bit(1'b1, r, oe);
    spi_bit(1'b1, r, oe);
    spi_bit(1'b1, r, oe);
    spi_end();
    cmd_addr(8'h03, 24'h000011, oe_seen);
    spi_byte(8'h00, rx, oa, ol);
    check_val("partial_wr", 32'(rx), 32'h5A);
    spi_end();

    // byte mode: one data byte, then HALT
    write_mode(8'h00);
    cmd_addr(8'h03, 24'h000010, oe_seen);
    spi_byte(8'h00, rx, oa, ol);
    check_val("byte_b0", 32'(rx), 32'hA5);
    spi_byte(8'h00, rx, oa, ol);
    check_val("byte_halt_so", 32'(rx), 32'h00);
    check_val("byte_halt_oe", 32'(oa), 32'd0);
    spi_end();

    // reset_n mid-READ clears outputs at once and restores the mode register
    write_mode(8'h80);
    cmd_addr(8'h03, 24'h000010, oe_seen);
    spi_bit(1'b0, r, oe);
    check_val("pre_rst_so", 32'(r), 32'd1);
    #3;
    reset_n = 1'b0;
    ce      = 1'b0;
    #1;
    check_val("rst_so", 32'(so), 32'd0);
    check_val("rst_so_oe", 32'(so_oe), 32'd0);
    @(negedge sclk);
    #2;
    reset_n = 1'b1;
    spi_byte(8'h05, rx, oa, ol);
    spi_byte(8'h00, rx, oa, ol);
    check_val("rst_mode", 32'(rx), 32'h40);
    spi_end();
    cmd_addr(8'h03, 24'h000010, oe_seen);
    spi_byte(8'h00, rx, oa, ol);
    check_val("rst_mem_kept", 32'(rx), 32'hA5);
    spi_end();

`ifdef SPI_SRAM_MODEL_STRICT_EN
    check_val("strict_err_clear", 32'(err), 32'd0);
    spi_byte(8'h9F, rx, oa, ol);
    spi_end();
    check_val("strict_err_set", 32'(err), 32'd1);
    spi_bit(1'b0, r, oe);
    spi_end();
    spi_end();
    check_val("strict_err_sticky", 32'(err), 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("strict_err_rst", 32'(err), 32'd0);
    reset_n = 1'b1;
`else
    spi_byte(8'h9F, rx, oa, ol);
    check_val("unknown_cmd_oe", 32'(oa), 32'd0);
    spi_byte(8'h00, rx, oa, ol);
    check_val("halt_oe", 32'(oa), 32'd0);
    spi_end();
    check_val("err_tied", 32'(err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
